// File: rtl/gate_tester_pkg.sv
// Shared definitions for the gate test sequencer: FSM states, memory command
// codes, default buffer addresses and the stimulus pair selector.
package gate_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_STIM = 3'd1,
    ST_FETCH_EXP  = 3'd2,
    ST_APPLY      = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_SAMPLE     = 3'd5,
    ST_WRITE      = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  localparam logic [7:0]  CMD_READ         = 8'h00;
  localparam logic [7:0]  CMD_WRITE        = 8'h01;
  localparam logic [15:0] DEFAULT_IN_ADDR  = 16'h0008;
  localparam logic [15:0] DEFAULT_OUT_ADDR = 16'h0000;

  // Pair idx of the stimulus byte: bits [2*idx+1 : 2*idx] give {A,B}.
  function automatic logic [1:0] pair_select(input logic [7:0] stim, input logic [1:0] idx);
    return stim[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Memory request/acknowledge bus between the sequencer (master) and the
// byte-wide memory (slave).
interface gate_test_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/gate_test_sequencer_settle_timer.sv
// Down-counter that times the settle window between a pin change and the
// output sample; zero is flagged straight off the counter register.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       count,
  input  logic [7:0] load_value,
  output logic       zero
);

  logic [7:0] count_r;

  // Load has priority; counting stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 8'd0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Fetches a stimulus byte and an expected truth table from memory, drives the
// four {A,B} pairs into an external gate, samples its output and writes back
// {mismatch, outputs}.
module gate_test_sequencer
  import gate_tester_pkg::*;
#(
  parameter int unsigned  SETTLE_CYCLES = 16,
  parameter logic [15:0]  IN_ADDR       = DEFAULT_IN_ADDR,
  parameter logic [15:0]  OUT_ADDR      = DEFAULT_OUT_ADDR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  gate_test_sequencer_if.master  mem,
  output logic [1:0]             dut_pinout,
  input  logic                   dut_out,
  output logic [7:0]             result,
  output logic                   busy,
  output logic                   done,
  output logic                   fail
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 32'd1);

  state_t     state_r;
  logic [7:0] stim_r;
  logic [3:0] exp_r;
  logic [1:0] idx_r;
  logic       load_s;
  logic       count_s;
  logic       zero_s;

  assign load_s  = (state_r == ST_APPLY);
  assign count_s = (state_r == ST_SETTLE);

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .count      (count_s),
    .load_value (SETTLE_LOAD),
    .zero       (zero_s)
  );

  // Sequencer FSM; every memory state raises mem_req in its first cycle and
  // drops it on the edge that sees mem_ack, so a stray ack with mem_req low is
  // never consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      stim_r        <= 8'd0;
      exp_r         <= 4'd0;
      idx_r         <= 2'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 16'd0;
      mem.mem_wdata <= 8'd0;
      dut_pinout    <= 2'b00;
      result        <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            result  <= 8'd0;
            fail    <= 1'b0;
            idx_r   <= 2'd0;
            busy    <= 1'b1;
            state_r <= ST_FETCH_STIM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH_STIM: begin
          if (!mem.mem_req) begin
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= CMD_READ[0];
            mem.mem_addr <= IN_ADDR;
          end else if (mem.mem_ack) begin
            stim_r      <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            state_r     <= ST_FETCH_EXP;
          end else begin
            state_r <= ST_FETCH_STIM;
          end
        end
        ST_FETCH_EXP: begin
          if (!mem.mem_req) begin
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= CMD_READ[0];
            mem.mem_addr <= IN_ADDR + 16'd1;
          end else if (mem.mem_ack) begin
            exp_r       <= mem.mem_rdata[3:0];
            mem.mem_req <= 1'b0;
            state_r     <= ST_APPLY;
          end else begin
            state_r <= ST_FETCH_EXP;
          end
        end
        ST_APPLY: begin
          dut_pinout <= pair_select(stim_r, idx_r);
          state_r    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (zero_s) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          result[{1'b0, idx_r}] <= dut_out;
          result[{1'b1, idx_r}] <= dut_out ^ exp_r[idx_r];
          if (idx_r == 2'd3) begin
            state_r <= ST_WRITE;
          end else begin
            idx_r   <= idx_r + 2'd1;
            state_r <= ST_APPLY;
          end
        end
        ST_WRITE: begin
          if (!mem.mem_req) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= CMD_WRITE[0];
            mem.mem_addr  <= OUT_ADDR;
            mem.mem_wdata <= result;
          end else if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= CMD_READ[0];
            done        <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_WRITE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          fail    <= |result[7:4];
          state_r <= ST_IDLE;
        end
        default: begin
          mem.mem_req <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
